elastic_pipe: RTL and testbench
===============================

// Module: elastic_pipe
// PURPOSE
//  Parametrised multi-entry pipe stage between valid/enable stages. Registers valid and data, and
//  breaks the enable path: e_up depends only on internal state. Full throughput (one packet per clk)
//  with DEPTH>=2. Drop-in successor to the single-entry pipe on long or congested datapaths.
// PARAMETERS
//  DATA_W    32  width of d_up/d_down
//  DEPTH      2  entries, 2..64; need not be a power of two
//  AF_LEVEL   DEPTH-1  occupancy at/above which af is asserted; 1..DEPTH
// PORTS
//  clk      in   1                    clock; all state updates on posedge
//  rst_n    in   1                    asynchronous, active-low reset
//  v_up     in   1                    valid from upstream
//  d_up     in   DATA_W               data from upstream
//  e_up     out  1                    enable to upstream; 1 = can accept this cycle
//  v_down   out  1                    valid to downstream
//  d_down   out  DATA_W               data to downstream
//  e_down   in   1                    enable from downstream
//  flush    in   1                    synchronous discard of all held packets
//  count    out  $clog2(DEPTH+1)      current occupancy
//  af       out  1                    almost-full, count >= AF_LEVEL
// BEHAVIOUR
//  - Reset (rst_n=0, any time, async): count=0, rd/wr ptr=0 -> v_down=0, e_up=1, af=0. Storage not reset.
//    Reset mid-burst drops all held packets. No transfer on the release edge unless v_up=1, e_up=1.
//  - push = v_up & e_up; pop = v_down & e_down. Both are evaluated at posedge.
//  - e_up = (count != DEPTH). It is a pure function of flops, with no comb path from e_down or v_up.
//  - v_down = (count != 0). d_down = mem[rd_ptr], read from flops, with no comb path from d_up.
//  - Latency: a packet pushed at edge N is visible on v_down/d_down after edge N. Empty bypass is not supported.
//  - push: mem[wr_ptr] <= d_up, wr_ptr advances. pop: rd_ptr advances. Ptr wrap at DEPTH-1 -> 0.
//  - count: push & !pop +1; pop & !push -1; both or neither unchanged.
//  - Full (count=DEPTH): e_up=0, so v_up is ignored and no write occurs. Pop still allowed; e_up=1 next cycle.
//  - Empty (count=0): v_down=0, so e_down is ignored and d_down is don't-care. Push allowed.
//  - Push+pop same cycle at any 0<count<DEPTH: order preserved, count constant.
//  - flush=1: next state count=0, ptrs=0. Flush overrides same-cycle push and pop, and the pushed packet is lost.
//  - Data is held stable while v_down=1 & e_down=0. Packets leave in arrival order. No drop, no duplication.
//  - af registered-equivalent: derived from count only.
//  - Illegal params (DEPTH<2, AF_LEVEL outside 1..DEPTH): elaboration-time $error.
// STRUCTURE
//  - Package pipe_pkg: function ptr_w(depth)=$clog2(depth), cnt_w(depth)=$clog2(depth+1); the
//    DEPTH_MIN=2 constant; typedef of the handshake struct {v, d} for users that bundle ports.
//  - Sub-module pipe_wrap_ctr #(MAX): ptr register with inc, clr, wrap at MAX-1, async reset.
//    Instantiated twice (rd, wr). Storage array, count, and output logic stay in elastic_pipe.
// TESTING
//  1 Reset: hold rst_n=0 with v_up=1 -> v_down=0, e_up=1, count=0, af=0. Assert rst_n asynchronously mid-cycle
//    -> outputs clear without waiting for clk.
//  2 Stream, DEPTH=2, e_down=1, v_up=1 with d_up=1,2,3..100 -> v_down from cycle 1, d_down=1..100 back-to-back,
//    e_up never 0, count stays 1.
//  3 Backpressure, DEPTH=4: push 0xA,0xB,0xC,0xD with e_down=0 -> count=4, e_up=0, af=1 (AF_LEVEL=3). A 5th
//    word 0xE is held by upstream; release e_down -> out A,B,C,D,E in order.
//  4 Full+simultaneous: at count=DEPTH drive v_up=1, e_down=1 -> pop only, count=DEPTH-1, next cycle e_up=1.
//    At count=2 do push+pop -> count stays 2.
//  5 Wrap, DEPTH=3 (non pow2): 20 random push/pop cycles against a scoreboard -> ordering exact, ptrs wrap 2->0.
//  6 Flush: count=3 with v_up=1, e_down=1, flush=1 -> next cycle count=0, v_down=0, e_up=1. Packet is lost.
//    Scoreboard is cleared.
//  Random soak: random v_up/e_down/flush with scoreboard, assertions on stable d_down under stall and
//  count<=DEPTH.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, limits and handshake bundle for the elastic pipe
package pipe_pkg;
  localparam int DEPTH_MIN = 2;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  typedef struct packed {
    logic        v;
    logic [31:0] d;
  } hs_t;
endpackage

// File: rtl/pipe_wrap_ctr.sv
// pipe_wrap_ctr: pointer register that wraps at MAX-1, with clear priority over increment
module pipe_wrap_ctr import pipe_pkg::*; #(
  parameter int MAX = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  input  logic                    clr,
  output logic [ptr_w(MAX)-1:0]   q
);
  localparam int W = ptr_w(MAX);
  // advance on inc, wrapping so non-power-of-two depths stay in range
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= (q == W'(MAX - 1)) ? '0 : q + W'(1);
endmodule

// File: rtl/elastic_pipe.sv
// elastic_pipe: multi-entry registered valid/enable stage; e_up depends only on occupancy
module elastic_pipe import pipe_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 2,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     v_up,
  input  logic [DATA_W-1:0]        d_up,
  output logic                     e_up,
  output logic                     v_down,
  output logic [DATA_W-1:0]        d_down,
  input  logic                     e_down,
  input  logic                     flush,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     af
);
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  if (DEPTH < DEPTH_MIN || AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_param
    $error("elastic_pipe: illegal DEPTH=%0d / AF_LEVEL=%0d", DEPTH, AF_LEVEL);
  end
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic push, pop;
  assign e_up   = count != CW'(DEPTH);
  assign v_down = count != '0;
  assign af     = count >= CW'(AF_LEVEL);
  assign push   = v_up & e_up;
  assign pop    = v_down & e_down;
  assign d_down = mem[rd_ptr];
  pipe_wrap_ctr #(.MAX(DEPTH)) u_wr (.clk(clk), .rst_n(rst_n), .inc(push), .clr(flush), .q(wr_ptr));
  pipe_wrap_ctr #(.MAX(DEPTH)) u_rd (.clk(clk), .rst_n(rst_n), .inc(pop),  .clr(flush), .q(rd_ptr));
  // storage is not reset; a flushed push is never written
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= d_up;
  // occupancy tracks push/pop imbalance; flush empties the pipe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (flush) count <= '0;
    else if (push != pop) count <= push ? count + CW'(1) : count - CW'(1);
endmodule

// File: tb/tb_elastic_pipe.sv
// tb_elastic_pipe: three depths driven in parallel and checked against per-instance queue models
module tb_elastic_pipe;
  import pipe_pkg::*;
  localparam int DEP [3] = '{2, 3, 4};
  logic clk = 0, rst_n = 0, v_up = 0, e_down = 0, flush = 0;
  logic [31:0] d_up = '0;
  logic        v_a [3], e_a [3], af_a [3];
  logic [31:0] dd_a [3];
  logic [2:0]  cnt_a [3];
  logic [31:0] mq [3][$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = DEP[g];
    logic [cnt_w(D)-1:0] c;
    elastic_pipe #(.DATA_W(32), .DEPTH(D)) u (
      .clk(clk), .rst_n(rst_n), .v_up(v_up), .d_up(d_up), .e_up(e_a[g]),
      .v_down(v_a[g]), .d_down(dd_a[g]), .e_down(e_down), .flush(flush),
      .count(c), .af(af_a[g]));
    assign cnt_a[g] = 3'(c);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // model: outputs follow queue contents; transition applied with inputs held for the coming edge
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      int sz;
      bit pu, po;
      if (!rst_n) mq[g].delete();
      sz = mq[g].size();
      chk($sformatf("d%0d.v_down", g), 64'(v_a[g]), 64'(sz != 0));
      chk($sformatf("d%0d.e_up", g), 64'(e_a[g]), 64'(sz < DEP[g]));
      chk($sformatf("d%0d.count", g), 64'(cnt_a[g]), 64'(sz));
      chk($sformatf("d%0d.af", g), 64'(af_a[g]), 64'(sz >= DEP[g] - 1));
      if (sz != 0) chk($sformatf("d%0d.d_down", g), 64'(dd_a[g]), 64'(mq[g][0]));
      if (rst_n) begin
        if (flush) mq[g].delete();
        else begin
          po = (sz != 0) && e_down;
          pu = v_up && (sz < DEP[g]);
          if (po) void'(mq[g].pop_front());
          if (pu) mq[g].push_back(d_up);
        end
      end
    end
  end
  initial begin
    logic [31:0] exp_seq [5];
    exp_seq = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
    v_up = 1;
    repeat (3) step;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst.d%0d.v_down", g), 64'(v_a[g]), 64'd0);
      chk($sformatf("rst.d%0d.e_up", g), 64'(e_a[g]), 64'd1);
      chk($sformatf("rst.d%0d.count", g), 64'(cnt_a[g]), 64'd0);
      chk($sformatf("rst.d%0d.af", g), 64'(af_a[g]), 64'd0);
    end
    rst_n = 1;
    e_down = 1;
    for (int i = 1; i <= 100; i++) begin
      d_up = 32'(i);
      step;
      chk("stream.d_down", 64'(dd_a[0]), 64'(i));
      chk("stream.count", 64'(cnt_a[0]), 64'd1);
      chk("stream.e_up", 64'(e_a[0]), 64'd1);
    end
    v_up = 0;
    step;
    e_down = 0;
    v_up = 1;
    for (int i = 0; i < 4; i++) begin
      d_up = exp_seq[i];
      step;
    end
    d_up = 32'hE;
    repeat (2) step;
    chk("bp.count", 64'(cnt_a[2]), 64'd4);
    chk("bp.e_up", 64'(e_a[2]), 64'd0);
    chk("bp.af", 64'(af_a[2]), 64'd1);
    e_down = 1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp.order%0d", k), 64'(dd_a[2]), 64'(exp_seq[k]));
      chk($sformatf("bp.v%0d", k), 64'(v_a[2]), 64'd1);
      step;
      if (k == 1) v_up = 0;
    end
    chk("bp.empty", 64'(v_a[2]), 64'd0);
    e_down = 0;
    v_up = 1;
    repeat (4) begin
      d_up = $urandom;
      step;
    end
    chk("full.count", 64'(cnt_a[2]), 64'd4);
    e_down = 1;
    step;
    chk("full.pop_only", 64'(cnt_a[2]), 64'd3);
    chk("full.e_up", 64'(e_a[2]), 64'd1);
    v_up = 0;
    step;
    v_up = 1;
    d_up = $urandom;
    step;
    chk("pushpop.count", 64'(cnt_a[2]), 64'd2);
    repeat (20) begin
      v_up = 1'($urandom_range(0, 1));
      e_down = 1'($urandom_range(0, 1));
      d_up = $urandom;
      step;
    end
    v_up = 0;
    e_down = 1;
    repeat (5) step;
    e_down = 0;
    v_up = 1;
    repeat (3) begin
      d_up = $urandom;
      step;
    end
    chk("flush.pre", 64'(cnt_a[2]), 64'd3);
    e_down = 1;
    flush = 1;
    step;
    flush = 0;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("flush.d%0d.count", g), 64'(cnt_a[g]), 64'd0);
      chk($sformatf("flush.d%0d.v_down", g), 64'(v_a[g]), 64'd0);
      chk($sformatf("flush.d%0d.e_up", g), 64'(e_a[g]), 64'd1);
    end
    e_down = 0;
    repeat (2) begin
      d_up = $urandom;
      step;
    end
    chk("arst.pre", 64'(cnt_a[2]), 64'd2);
    #2 rst_n = 0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("arst.d%0d.count", g), 64'(cnt_a[g]), 64'd0);
      chk($sformatf("arst.d%0d.v_down", g), 64'(v_a[g]), 64'd0);
      chk($sformatf("arst.d%0d.e_up", g), 64'(e_a[g]), 64'd1);
    end
    step;
    rst_n = 1;
    repeat (3000) begin
      v_up = ($urandom_range(0, 3) != 0);
      e_down = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 63) == 0);
      d_up = $urandom;
      step;
    end
    flush = 0;
    v_up = 0;
    e_down = 1;
    repeat (6) step;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
